// File: rtl/counter8_pkg.sv
// rtl/counter8_pkg.sv - shared encodings and defaults for the counter8 command sequencer
package counter8_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/counter8_bound_det.sv
// rtl/counter8_bound_det.sv - flags when the counter sits on the boundary for its direction
import counter8_pkg::*;

module counter8_bound_det #(
  parameter int COUNT_WIDTH = counter8_pkg::COUNT_WIDTH
) (
  input  logic [COUNT_WIDTH-1:0] i_dcout,
  input  logic                   i_dir,
  output logic                   o_at_bound
);

  // Counting up the boundary is all-ones, counting down it is zero.
  assign o_at_bound = i_dir ? (i_dcout == '1) : (i_dcout == '0);

endmodule

// File: rtl/counter8_cmd_seq.sv
// rtl/counter8_cmd_seq.sv - turns load/count commands into control strobes for the up/down counter
import counter8_pkg::*;

module counter8_cmd_seq #(
  parameter int COUNT_WIDTH = counter8_pkg::COUNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [COUNT_WIDTH-1:0] i_cmd_val,
  input  logic                   i_cmd_wrapstop,
  output logic                   o_loadn,
  output logic [COUNT_WIDTH-1:0] o_preld_val,
  output logic                   o_updown,
  output logic                   o_cnt_en,
  input  logic [COUNT_WIDTH-1:0] i_dcout,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_sat,
  output logic                   o_wrapped
);

  state_e                   r_state;
  state_e                   w_state_next;
  logic [COUNT_WIDTH-1:0]   r_preld_val;
  logic [COUNT_WIDTH-1:0]   r_remaining;
  logic                     r_dir;
  logic                     r_wrapstop;
  logic                     r_sat;
  logic                     r_wrapped;
  logic                     w_accept;
  logic                     w_at_bound;
  logic                     w_stop_now;
  op_e                      w_op;

  assign w_op       = op_e'(i_cmd_op);
  assign w_stop_now = w_at_bound && !r_wrapstop;

  counter8_bound_det #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_bound_det (
    .i_dcout    (i_dcout),
    .i_dir      (r_dir),
    .o_at_bound (w_at_bound)
  );

  // State register; reset abandons any command in flight.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and state-decoded control outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_cmd_ready  = 1'b0;
    o_busy       = 1'b1;
    o_loadn      = 1'b1;
    o_done       = 1'b0;
    o_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        w_accept    = i_cmd_valid;
        if (i_cmd_valid) begin
          case (w_op)
            OP_NOP:  w_state_next = DONE;
            OP_LOAD: w_state_next = LOAD;
            default: w_state_next = (i_cmd_val == '0) ? DONE : RUN;
          endcase
        end
      end
      LOAD: begin
        o_loadn      = 1'b0;
        w_state_next = DONE;
      end
      RUN: begin
        // Hold the enable off on a stop boundary so the counter never moves past it.
        o_cnt_en = !w_stop_now;
        if (w_stop_now || (r_remaining == COUNT_WIDTH'(1))) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Command latches, step counter and the sat/wrapped status flags.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_preld_val <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b1;
      r_wrapstop  <= 1'b0;
      r_sat       <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sat     <= 1'b0;
        r_wrapped <= 1'b0;
        if (w_op == OP_LOAD) begin
          r_preld_val <= i_cmd_val;
        end
        if ((w_op == OP_UP) || (w_op == OP_DOWN)) begin
          r_remaining <= i_cmd_val;
          r_dir       <= (w_op == OP_UP);
          r_wrapstop  <= i_cmd_wrapstop;
        end
      end
      if (r_state == RUN) begin
        if (w_stop_now) begin
          r_sat <= 1'b1;
        end else begin
          r_remaining <= r_remaining - COUNT_WIDTH'(1);
          if (w_at_bound) begin
            r_wrapped <= 1'b1;
          end
        end
      end
    end
  end

  assign o_preld_val = r_preld_val;
  assign o_updown    = r_dir;
  assign o_sat       = r_sat;
  assign o_wrapped   = r_wrapped;

endmodule

// File: tb/tb_counter8_cmd_seq.sv
// tb/tb_counter8_cmd_seq.sv - scoreboard bench for the counter8 command sequencer
module tb_counter8_cmd_seq;
  import counter8_pkg::*;

  logic       clk = 1'b0;
  logic       i_resetn;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic [7:0] i_cmd_val;
  logic       i_cmd_wrapstop;
  logic       o_loadn;
  logic [7:0] o_preld_val;
  logic       o_updown;
  logic       o_cnt_en;
  logic [7:0] i_dcout;
  logic       o_busy;
  logic       o_done;
  logic       o_sat;
  logic       o_wrapped;

  always #5 clk = ~clk;

  counter8_cmd_seq #(.COUNT_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_resetn       (i_resetn),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_op       (i_cmd_op),
    .i_cmd_val      (i_cmd_val),
    .i_cmd_wrapstop (i_cmd_wrapstop),
    .o_loadn        (o_loadn),
    .o_preld_val    (o_preld_val),
    .o_updown       (o_updown),
    .o_cnt_en       (o_cnt_en),
    .i_dcout        (i_dcout),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_sat          (o_sat),
    .o_wrapped      (o_wrapped)
  );

  // Behavioural 8-bit up/down counter driven by the sequencer.
  logic [7:0] r_cnt = 8'h00;
  always @(posedge clk) begin
    if (!o_loadn) r_cnt <= o_preld_val;
    else if (o_cnt_en) r_cnt <= o_updown ? r_cnt + 8'd1 : r_cnt - 8'd1;
  end
  assign i_dcout = r_cnt;

  typedef struct {
    logic       sat;
    logic       wrapped;
    logic [7:0] val;
    int         en;
    logic       dir;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         en_cnt  = 0;
  int         dir_bad = 0;
  logic [7:0] exp_cnt = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] start, input logic [1:0] op,
                                 input logic [7:0] n, input logic ws);
    exp_t e;
    logic b;
    e.sat = 1'b0; e.wrapped = 1'b0; e.val = start; e.en = 0; e.dir = (op == 2'b10);
    if (op == 2'b01) e.val = n;
    if (op[1]) begin
      for (int i = 0; i < int'(n); i++) begin
        b = e.dir ? (e.val == 8'hFF) : (e.val == 8'h00);
        if (b && !ws) begin
          e.sat = 1'b1;
          break;
        end
        if (b) e.wrapped = 1'b1;
        e.val = e.dir ? e.val + 8'd1 : e.val - 8'd1;
        e.en++;
      end
    end
    return e;
  endfunction

  // Retirement monitor: counts enable cycles and scores each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!i_resetn) begin
      sb.delete();
      en_cnt  = 0;
      dir_bad = 0;
    end else if (o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("done_sat", o_sat, e.sat);
        chk("done_wrapped", o_wrapped, e.wrapped);
        chk("done_dcout", r_cnt, e.val);
        chk("done_en_cycles", en_cnt, e.en);
        chk("done_dir", dir_bad, 0);
      end
      en_cnt  = 0;
      dir_bad = 0;
    end else if (o_cnt_en) begin
      en_cnt++;
      if (sb.size() == 0 || o_updown !== sb[0].dir) dir_bad++;
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] v, input logic ws, output int waited);
    exp_t e;
    e = model(exp_cnt, op, v, ws);
    exp_cnt = e.val;
    sb.push_back(e);
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_val = v; i_cmd_wrapstop = ws;
    waited = 0;
    while (!o_cmd_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) chk("accept_timeout", waited, 0);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0; i_cmd_op = 2'b00;
  endtask

  task automatic wait_done();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_done && c < 400);
    chk("done_seen", o_done, 1);
    chk("ready_low_in_done", o_cmd_ready, 0);
  endtask

  initial begin
    int w;
    logic [7:0] held;
    i_resetn = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = 2'b00; i_cmd_val = 8'h00; i_cmd_wrapstop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_loadn", o_loadn, 1);
    chk("rst_updown", o_updown, 1);
    chk("rst_cnt_en", o_cnt_en, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sat_wrapped", {o_sat, o_wrapped}, 0);
    chk("rst_preld", o_preld_val, 0);
    i_resetn = 1'b1;
    exp_cnt = r_cnt;
    @(negedge clk);

    // LOAD 0x5A: one strobe cycle, then done.
    send(2'b01, 8'h5A, 1'b0, w);
    @(negedge clk);
    chk("load_strobe", o_loadn, 0);
    chk("load_preld", o_preld_val, 8'h5A);
    chk("load_no_en", o_cnt_en, 0);
    chk("load_busy", o_busy, 1);
    @(negedge clk);
    chk("load_done", o_done, 1);
    chk("load_strobe_off", o_loadn, 1);
    @(negedge clk);
    chk("load_idle", o_cmd_ready, 1);

    // UP 4 wrap-mode from 0x10.
    send(2'b01, 8'h10, 1'b0, w); wait_done();
    send(2'b10, 8'd4, 1'b1, w); wait_done();
    chk("up4_dir", o_updown, 1);
    chk("up4_val", r_cnt, 8'h14);

    // UP 5 stop-mode from 0xFD saturates at 0xFF.
    send(2'b01, 8'hFD, 1'b0, w); wait_done();
    send(2'b10, 8'd5, 1'b0, w); wait_done();
    chk("up5_sat", o_sat, 1);
    repeat (3) @(negedge clk);
    chk("up5_hold", r_cnt, 8'hFF);

    // DOWN 3 wrap-mode from 0x01 passes through zero.
    send(2'b01, 8'h01, 1'b0, w); wait_done();
    send(2'b11, 8'd3, 1'b1, w); wait_done();
    chk("down3_wrapped", o_wrapped, 1);
    chk("down3_dir", o_updown, 0);
    chk("down3_val", r_cnt, 8'hFE);

    // NOP held while busy is only taken once the sequencer is idle again.
    send(2'b10, 8'd10, 1'b1, w);
    send(2'b00, 8'd0, 1'b0, w);
    chk("nop_held_cycles", w, 11);
    wait_done();

    // UP N=0 retires the cycle after accept with no enables.
    send(2'b10, 8'd0, 1'b1, w);
    @(negedge clk);
    chk("up0_done", o_done, 1);
    chk("up0_no_en", o_cnt_en, 0);

    // A short burst of random commands.
    for (int k = 0; k < 8; k++) begin
      logic [1:0] op;
      logic [7:0] v;
      op = 2'($urandom_range(0, 3));
      v  = op[1] ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      send(op, v, 1'($urandom_range(0, 1)), w);
      wait_done();
    end

    // Reset after three steps of UP 10 abandons the command.
    send(2'b10, 8'd10, 1'b1, w);
    repeat (3) @(negedge clk);
    i_resetn = 1'b0;
    @(negedge clk);
    chk("midrst_ready", o_cmd_ready, 1);
    chk("midrst_cnt_en", o_cnt_en, 0);
    chk("midrst_loadn", o_loadn, 1);
    chk("midrst_busy", o_busy, 0);
    @(negedge clk);
    i_resetn = 1'b1;
    held = r_cnt;
    exp_cnt = r_cnt;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_no_en", o_cnt_en, 0);
      chk("postrst_no_done", o_done, 0);
    end
    chk("postrst_hold", r_cnt, held);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
